apb_ram_arbiter: RTL and testbench
==================================

Name: apb_ram_arbiter

Overview:
- Two-requester APB master that shares a single APB RAM slave between two internal clients, e.g. the CPU-side port and a DMA-side port.
- Each client uses a simple valid/ready request channel and gets a one-cycle done pulse with read data and an error flag.
- Arbitration is round-robin. The block sequences the APB SETUP and ACCESS phases, honours pready wait states, and aborts with an error on a slave timeout.

Parameters:
- ADDR_W, 32, width of paddr and the request addresses.
- DATA_W, 32, width of the data buses.
- TIMEOUT, 16, maximum number of ACCESS-phase cycles before abort. 0 disables the timeout.

Ports:
- pclk  in  1  clock; all logic is on its rising edge.
- preset  in  1  synchronous, active-high reset.
- req0_valid  in  1  client 0 request.
- req0_write  in  1  1 = write, 0 = read.
- req0_addr  in  ADDR_W  client 0 address.
- req0_wdata  in  DATA_W  client 0 write data.
- req0_ready  out  1  request accepted this cycle.
- req0_done  out  1  one-cycle completion pulse.
- req0_rdata  out  DATA_W  read data, valid while req0_done is high.
- req0_err  out  1  timeout error, valid while req0_done is high.
- req1_*  same set as req0_*, for client 1.
- paddr  out  ADDR_W  APB address.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- pwdata  out  DATA_W  APB write data.
- prdata  in  DATA_W  APB read data.
- pready  in  1  APB ready.

Behaviour:
- Clock and reset: one clock, pclk. Reset preset is synchronous and active-high.
- Reset values (all registered outputs): psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, reqN_done=0, reqN_rdata=0, reqN_err=0. State=IDLE. Priority pointer prio=0. Timeout counter=0.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - If no request is valid, stay in IDLE.
  - Otherwise grant a client: the single valid requester; if both are valid, client prio.
  - reqN_ready is combinational and high only in IDLE for the granted client.
  - On that edge: latch addr, write and wdata into the paddr/pwrite/pwdata registers; record the granted id; set prio to the other client; go to SETUP.
- SETUP: psel=1, penable=0. Always goes to ACCESS on the next edge. The counter is cleared.
- ACCESS: psel=1, penable=1, with paddr, pwrite and pwdata held stable.
  - pready=1: at that edge go to IDLE; psel=0 and penable=0 next cycle. Granted reqN_done=1 for one cycle; reqN_rdata = prdata for reads, 0 for writes; reqN_err=0.
  - pready=0 and counter == TIMEOUT-1 (TIMEOUT≠0): at that edge go to IDLE. done=1, err=1, rdata=0.
  - Otherwise the counter increments.
  - pready on the last allowed cycle counts as success; success beats timeout.
- Done pulse timing: done is asserted during the first IDLE cycle after ACCESS. A new request may be granted in that same cycle.
- Latency and throughput: minimum 3 cycles per transfer (IDLE grant → SETUP → ACCESS), with done one cycle after the last ACCESS cycle. Back-to-back transfers run at one per 3 cycles.
- The non-granted client's done, rdata and err stay 0. Ready and done are never asserted to both clients in the same cycle.
- Client obligations: hold valid, addr, write and wdata stable until ready. A client may drop valid before ready; this is legal and no transfer occurs.
- prio changes only on a grant. Example: prio=1, then client 0 alone is granted → prio becomes 1.
- Reset in SETUP or ACCESS: abort next edge to the reset values. No done pulse; the pending transfer is lost.
- The counter is wide enough for TIMEOUT; values of TIMEOUT up to 2^16 are supported.

Test Plan:
1. Client 0 writes addr 5, data 0xDEADBEEF to a zero-wait RAM, then reads addr 5 → req0_ready in the IDLE cycle; psel/penable sequence 10→11; req0_done 3 cycles after the grant edge; read returns req0_rdata=0xDEADBEEF, err=0.
2. Both valid continuously from reset: client 0 writes addr 1..4, client 1 writes addr 101..104 → grant order 0,1,0,1,… with no done overlap; RAM readback matches all 8 writes.
3. Slave holds pready=0 for 3 ACCESS cycles, then 1, on a read of addr 7 (data 0x12345678) → ACCESS lasts 4 cycles with paddr stable; req1_done with rdata=0x12345678, err=0.
4. pready tied 0, TIMEOUT=16 → exactly 16 ACCESS cycles; done with err=1, rdata=0; psel=0 the next cycle; the next request proceeds normally.
5. pready=1 on exactly the 16th ACCESS cycle → success: err=0, valid rdata.
6. preset asserted during ACCESS → psel=penable=0 next cycle; no done pulse; prio=0; a following client 1 request completes normally.

Source files
------------

// File: rtl/apb_ram_arbiter_if.sv
// Client request/done channels plus APB bus; master = arbiter view, slave = environment view.
// Every request and done channel and the APB signals share one clock.
interface apb_ram_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req0_valid;
  logic              req0_write;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              req0_ready;
  logic              req0_done;
  logic [DATA_W-1:0] req0_rdata;
  logic              req0_err;

  logic              req1_valid;
  logic              req1_write;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              req1_ready;
  logic              req1_done;
  logic [DATA_W-1:0] req1_rdata;
  logic              req1_err;

  logic [ADDR_W-1:0] paddr;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;

  modport master (
    input  req0_valid, req0_write, req0_addr, req0_wdata,
    output req0_ready, req0_done, req0_rdata, req0_err,
    input  req1_valid, req1_write, req1_addr, req1_wdata,
    output req1_ready, req1_done, req1_rdata, req1_err,
    output paddr, psel, penable, pwrite, pwdata,
    input  prdata, pready
  );

  modport slave (
    output req0_valid, req0_write, req0_addr, req0_wdata,
    input  req0_ready, req0_done, req0_rdata, req0_err,
    output req1_valid, req1_write, req1_addr, req1_wdata,
    input  req1_ready, req1_done, req1_rdata, req1_err,
    input  paddr, psel, penable, pwrite, pwdata,
    output prdata, pready
  );
endinterface

// File: rtl/apb_ram_arbiter.sv
// Round-robin two-client APB master: >=3 cycles per transfer, done one cycle after the last ACCESS cycle.
// Clients are held off by ready (IDLE only); slave stalls via pready, bounded by TIMEOUT ACCESS cycles.
module apb_ram_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic pclk,
  input  logic preset,
  apb_ram_arbiter_if.master bus
);
  localparam int CNT_W = 17;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t            state;
  state_t            state_nx;
  logic              prio;
  logic              id_q;
  logic              gnt_vld;
  logic              gnt_id;
  logic              tmo;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rd_dat;

  always_ff @(posedge pclk) begin
    if (preset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    gnt_vld  = 1'b0;
    gnt_id   = 1'b0;
    tmo      = 1'b0;
    case (state)
      IDLE: begin
        // A grant during reset would be lost, so ready is held off then.
        if (!preset && (bus.req0_valid || bus.req1_valid)) begin
          gnt_vld  = 1'b1;
          gnt_id   = (bus.req0_valid && bus.req1_valid) ? prio : bus.req1_valid;
          state_nx = SETUP;
        end
      end
      SETUP: state_nx = ACCESS;
      ACCESS: begin
        tmo = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));
        if (bus.pready || tmo) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    bus.req0_ready = gnt_vld && !gnt_id;
    bus.req1_ready = gnt_vld && gnt_id;
  end

  // pready wins over a simultaneous timeout.
  assign rd_dat = (bus.pready && !bus.pwrite) ? bus.prdata : '0;

  always_ff @(posedge pclk) begin
    if (preset) begin
      bus.psel       <= 1'b0;
      bus.penable    <= 1'b0;
      bus.pwrite     <= 1'b0;
      bus.paddr      <= '0;
      bus.pwdata     <= '0;
      bus.req0_done  <= 1'b0;
      bus.req0_rdata <= '0;
      bus.req0_err   <= 1'b0;
      bus.req1_done  <= 1'b0;
      bus.req1_rdata <= '0;
      bus.req1_err   <= 1'b0;
      prio           <= 1'b0;
      id_q           <= 1'b0;
      cnt            <= '0;
    end else begin
      bus.req0_done  <= 1'b0;
      bus.req0_rdata <= '0;
      bus.req0_err   <= 1'b0;
      bus.req1_done  <= 1'b0;
      bus.req1_rdata <= '0;
      bus.req1_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_vld) begin
            bus.paddr   <= gnt_id ? bus.req1_addr  : bus.req0_addr;
            bus.pwrite  <= gnt_id ? bus.req1_write : bus.req0_write;
            bus.pwdata  <= gnt_id ? bus.req1_wdata : bus.req0_wdata;
            bus.psel    <= 1'b1;
            bus.penable <= 1'b0;
            id_q        <= gnt_id;
            prio        <= ~gnt_id;
          end
        end
        SETUP: begin
          bus.penable <= 1'b1;
          cnt         <= '0;
        end
        ACCESS: begin
          if (bus.pready || tmo) begin
            bus.psel    <= 1'b0;
            bus.penable <= 1'b0;
            if (!id_q) begin
              bus.req0_done  <= 1'b1;
              bus.req0_rdata <= rd_dat;
              bus.req0_err   <= !bus.pready;
            end else begin
              bus.req1_done  <= 1'b1;
              bus.req1_rdata <= rd_dat;
              bus.req1_err   <= !bus.pready;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_ram_arbiter.sv
// Bench for apb_ram_arbiter: APB RAM slave with per-address wait states, random clients,
// and a transaction-level model predicting grants, bus phases and done results.
module tb_apb_ram_arbiter;
  localparam int TMO = 16;

  logic pclk = 1'b0;
  logic preset = 1'b1;
  always #5 pclk = ~pclk;

  apb_ram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  apb_ram_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .pclk(pclk),
    .preset(preset),
    .bus(bus)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  int          wait_tab [256];
  logic [31:0] ram      [256];
  logic [31:0] ref_mem  [256];
  int          acc_cnt = 0;
  int          cur_wait = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // APB RAM slave: wait states per address, pready after that many stalled ACCESS cycles.
  assign bus.prdata = ram[bus.paddr[7:0]];
  assign bus.pready = bus.psel && bus.penable && (acc_cnt == cur_wait);

  always @(posedge pclk) begin
    cyc <= cyc + 1;
    if (bus.psel && !bus.penable) cur_wait <= wait_tab[bus.paddr[7:0]];
    if (bus.psel && bus.penable && !bus.pready) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
    if (bus.psel && bus.penable && bus.pready && bus.pwrite) ram[bus.paddr[7:0]] <= bus.pwdata;
  end

  // Transaction-level reference model.
  typedef struct {
    int          id;
    int          gcyc;
    int          dcyc;
    logic [31:0] addr;
    bit          wr;
    logic [31:0] wd;
    logic [31:0] rd;
    bit          err;
  } txn_t;

  txn_t cur;
  bit   pend = 1'b0;
  int   prio_m = 0;

  always @(negedge pclk) begin
    bit exp_ps, exp_pe, ed, g0, g1, v0, v1;
    int w;
    if (mon_en) begin
      exp_ps = pend && (cyc > cur.gcyc) && (cyc < cur.dcyc);
      exp_pe = pend && (cyc > cur.gcyc + 1) && (cyc < cur.dcyc);
      chk("psel", bus.psel, exp_ps);
      chk("penable", bus.penable, exp_pe);
      if (exp_ps) begin
        chk("paddr", bus.paddr, cur.addr);
        chk("pwrite", bus.pwrite, cur.wr);
        if (cur.wr) chk("pwdata", bus.pwdata, cur.wd);
      end
      ed = pend && (cyc == cur.dcyc);
      chk("done0", bus.req0_done, ed && cur.id == 0);
      chk("done1", bus.req1_done, ed && cur.id == 1);
      chk("rdata0", bus.req0_rdata, (ed && cur.id == 0) ? cur.rd : 32'h0);
      chk("rdata1", bus.req1_rdata, (ed && cur.id == 1) ? cur.rd : 32'h0);
      chk("err0", bus.req0_err, ed && cur.id == 0 && cur.err);
      chk("err1", bus.req1_err, ed && cur.id == 1 && cur.err);
      if (ed) pend = 1'b0;
      if (preset) begin
        pend = 1'b0;
        prio_m = 0;
      end else begin
        v0 = bus.req0_valid;
        v1 = bus.req1_valid;
        g0 = !pend && v0 && (!v1 || prio_m == 0);
        g1 = !pend && v1 && (!v0 || prio_m == 1);
        chk("ready0", bus.req0_ready, g0);
        chk("ready1", bus.req1_ready, g1);
        if (g0 || g1) begin
          cur.id   = g0 ? 0 : 1;
          cur.addr = g0 ? bus.req0_addr : bus.req1_addr;
          cur.wr   = g0 ? bus.req0_write : bus.req1_write;
          cur.wd   = g0 ? bus.req0_wdata : bus.req1_wdata;
          cur.gcyc = cyc;
          w        = wait_tab[cur.addr[7:0]];
          cur.err  = (w >= TMO);
          cur.dcyc = cyc + 3 + (cur.err ? TMO - 1 : w);
          cur.rd   = (!cur.wr && !cur.err) ? ref_mem[cur.addr[7:0]] : 32'h0;
          if (cur.wr && !cur.err) ref_mem[cur.addr[7:0]] = cur.wd;
          prio_m = g0 ? 1 : 0;
          pend = 1'b1;
        end
      end
    end
  end

  task automatic drive(input int c, input bit v, input bit w, input logic [31:0] a, input logic [31:0] d);
    if (c == 0) begin
      bus.req0_valid = v; bus.req0_write = w; bus.req0_addr = a; bus.req0_wdata = d;
    end else begin
      bus.req1_valid = v; bus.req1_write = w; bus.req1_addr = a; bus.req1_wdata = d;
    end
  endtask

  task automatic issue(input int c, input bit w, input logic [31:0] a, input logic [31:0] d, input bit allow_drop);
    bit rdy;
    drive(c, 1'b1, w, a, d);
    for (int k = 0; k < 400; k++) begin
      @(negedge pclk);
      rdy = (c == 0) ? bus.req0_ready : bus.req1_ready;
      if (rdy || (allow_drop && $urandom_range(0, 19) == 0)) begin
        @(posedge pclk);
        #1;
        drive(c, 1'b0, 1'b0, 32'h0, 32'h0);
        return;
      end
    end
    chk("ready_timeout", 1'b0, 1'b1);
    drive(c, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic wait_done(input int c, output logic [31:0] rd, output logic er);
    rd = 32'hx;
    er = 1'bx;
    for (int k = 0; k < 400; k++) begin
      @(negedge pclk);
      if ((c == 0) ? bus.req0_done : bus.req1_done) begin
        rd = (c == 0) ? bus.req0_rdata : bus.req1_rdata;
        er = (c == 0) ? bus.req0_err : bus.req1_err;
        @(posedge pclk);
        #1;
        return;
      end
    end
    chk("done_timeout", 1'b0, 1'b1);
  endtask

  task automatic client_rand(input int c, input int n);
    int gap;
    for (int i = 0; i < n; i++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) begin @(posedge pclk); #1; end
      issue(c, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)), $urandom, 1'b1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    logic        e;
    bit          hit;
    int          sel;

    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 256; i++) begin
      ram[i] = 32'h0;
      ref_mem[i] = 32'h0;
      sel = $urandom_range(0, 9);
      wait_tab[i] = (sel < 7) ? $urandom_range(0, 3) : (sel == 7) ? 15 : (sel == 8) ? 16 : 25;
    end
    for (int i = 1; i <= 8; i++) wait_tab[i] = 0;
    for (int i = 101; i <= 104; i++) wait_tab[i] = 0;
    wait_tab[5] = 0; wait_tab[7] = 3; wait_tab[9] = 100; wait_tab[10] = 15;

    // Reset values.
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    chk("rst_psel", bus.psel, 1'b0);
    chk("rst_penable", bus.penable, 1'b0);
    chk("rst_pwrite", bus.pwrite, 1'b0);
    chk("rst_paddr", bus.paddr, 32'h0);
    chk("rst_pwdata", bus.pwdata, 32'h0);
    chk("rst_done", {bus.req0_done, bus.req1_done}, 2'b00);
    chk("rst_rdata", {bus.req0_rdata, bus.req1_rdata}, 64'h0);
    chk("rst_err", {bus.req0_err, bus.req1_err}, 2'b00);
    @(posedge pclk);
    #1;
    preset = 1'b0;
    mon_en = 1'b1;

    // Zero-wait write then read.
    issue(0, 1'b1, 32'd5, 32'hDEADBEEF, 1'b0);
    wait_done(0, r, e);
    chk("t1_wr_err", e, 1'b0);
    issue(0, 1'b0, 32'd5, 32'h0, 1'b0);
    wait_done(0, r, e);
    chk("t1_rd_data", r, 32'hDEADBEEF);
    chk("t1_rd_err", e, 1'b0);

    // Both clients continuously valid: alternating grants.
    fork
      for (int i = 1; i <= 4; i++) issue(0, 1'b1, 32'(i), 32'hA000_0000 + 32'(i), 1'b0);
      for (int i = 1; i <= 4; i++) issue(1, 1'b1, 32'(100 + i), 32'hB000_0000 + 32'(i), 1'b0);
    join
    repeat (5) begin @(posedge pclk); #1; end
    for (int i = 1; i <= 4; i++) begin
      issue(0, 1'b0, 32'(i), 32'h0, 1'b0);
      wait_done(0, r, e);
      chk("t2_rb0", r, 32'hA000_0000 + 32'(i));
      issue(1, 1'b0, 32'(100 + i), 32'h0, 1'b0);
      wait_done(1, r, e);
      chk("t2_rb1", r, 32'hB000_0000 + 32'(i));
    end

    // Three wait states on addr 7.
    issue(1, 1'b1, 32'd7, 32'h12345678, 1'b0);
    wait_done(1, r, e);
    issue(1, 1'b0, 32'd7, 32'h0, 1'b0);
    wait_done(1, r, e);
    chk("t3_rd_data", r, 32'h12345678);
    chk("t3_rd_err", e, 1'b0);

    // Slave never ready: timeout, then a normal transfer.
    issue(0, 1'b0, 32'd9, 32'h0, 1'b0);
    wait_done(0, r, e);
    chk("t4_tmo_err", e, 1'b1);
    chk("t4_tmo_rdata", r, 32'h0);
    issue(1, 1'b0, 32'd5, 32'h0, 1'b0);
    wait_done(1, r, e);
    chk("t4_next_data", r, 32'hDEADBEEF);
    chk("t4_next_err", e, 1'b0);

    // pready on the last allowed ACCESS cycle.
    issue(0, 1'b1, 32'd10, 32'hCAFEF00D, 1'b0);
    wait_done(0, r, e);
    chk("t5_wr_err", e, 1'b0);
    issue(0, 1'b0, 32'd10, 32'h0, 1'b0);
    wait_done(0, r, e);
    chk("t5_rd_data", r, 32'hCAFEF00D);
    chk("t5_rd_err", e, 1'b0);

    // Reset during ACCESS: transfer dropped, prio back to client 0.
    issue(1, 1'b0, 32'd9, 32'h0, 1'b0);
    hit = 1'b0;
    for (int k = 0; k < 50 && !hit; k++) begin
      @(negedge pclk);
      hit = bus.psel && bus.penable;
    end
    chk("t6_reach_access", hit, 1'b1);
    @(posedge pclk);
    #1;
    preset = 1'b1;
    @(posedge pclk);
    #1;
    preset = 1'b0;
    chk("t6_psel", bus.psel, 1'b0);
    chk("t6_penable", bus.penable, 1'b0);
    fork
      issue(0, 1'b0, 32'd1, 32'h0, 1'b0);
      begin
        issue(1, 1'b0, 32'd5, 32'h0, 1'b0);
        wait_done(1, r, e);
        chk("t6_next_data", r, 32'hDEADBEEF);
        chk("t6_next_err", e, 1'b0);
      end
    join

    // Random traffic from both clients.
    fork
      client_rand(0, 60);
      client_rand(1, 60);
    join
    repeat (40) begin @(posedge pclk); #1; end
    chk("drained", pend, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
